imem_loader: RTL
================

Name: imem_loader

Overview:
Boot-time program loader that sits directly upstream of the single-cycle core's instruction memory. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words to consecutive instruction-memory addresses starting at 0, holding the core until the image is complete and its checksum matches. It is the only writer of instruction memory.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width.
MAX_WORDS, 256, largest accepted image length in words; must be ≤ 2^ADDR_WIDTH.

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
restart  input  1  one-cycle pulse that aborts and re-arms the loader
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid this cycle
byte_ready  output  1  loader accepts byte_in this cycle
imem_we  output  1  instruction-memory write enable, one-cycle pulse
imem_addr  output  ADDR_WIDTH  instruction-memory word address
imem_wd  output  32  instruction word to write
core_hold  output  1  holds the core's program counter and register writes while high
done  output  1  image loaded and verified
error  output  1  image rejected

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high and has priority over every other input.
- Reset values: state=LEN_HI, imem_we=0, imem_addr=0, imem_wd=0, core_hold=1, done=0, error=0, and the length, word, byte and checksum counters all 0.
- Handshake: a byte is accepted on a cycle where byte_valid & byte_ready.
  - byte_ready = (state is LEN_HI, LEN_LO, DATA or CHECK) & ~reset. It is combinational from state.
  - byte_in is ignored whenever no byte is accepted. byte_valid gaps of any length are legal.
- Stream format: length hi byte, length lo byte (16-bit word count N), then 4·N data bytes with each word MSB first, then one checksum byte.
  - The checksum byte must equal the XOR of all preceding bytes, including both length bytes.
- States:
  - LEN_HI: accept byte, store it as length[15:8], go to LEN_LO.
  - LEN_LO: accept byte, store it as length[7:0].
    - If the 16-bit length is 0 or greater than MAX_WORDS, go to ERROR.
    - Otherwise go to DATA.
  - DATA: shift each accepted byte into a 32-bit assembly register, MSB first.
    - On the 4th byte of a word, in the next cycle: imem_we=1 for exactly one cycle, imem_wd=the assembled word, imem_addr=word index. The word index then increments.
    - byte_ready stays 1 during the write cycle, so back-to-back bytes are accepted with no bubbles.
    - After the 4th byte of word N-1 is accepted, go to CHECK.
  - CHECK: accept one byte.
    - If it equals the running XOR, go to DONE.
    - Otherwise go to ERROR.
  - DONE: done=1, core_hold=0. Stay until restart or reset.
  - ERROR: error=1, core_hold=1. Stay until restart or reset.
- imem_addr holds its last written value between writes.
- Restart: restart=1 in any state moves to LEN_HI next cycle.
  - Clears the counters, checksum, done and error; sets core_hold=1 and imem_addr=0.
  - Any byte presented in that cycle is not accepted; byte_ready=0 in the restart cycle.
  - A partially written image is abandoned. There is no rollback of words already written.
- Reset or restart mid-load: any pending write of the final word still issues its imem_we in the next cycle only if it was already registered. Otherwise no write issues.
- core_hold is registered. It falls in the same cycle done rises.
- The checksum XOR covers every accepted byte. The CHECK byte itself is compared but not accumulated.

Test Plan:
- Normal load:
  - Stimulus: reset, then bytes 00 02 20 08 00 05 8C 09 00 04 AE with continuous valid.
  - Required: imem writes (0, 0x20080005) and (1, 0x8C090004), each a single-cycle imem_we; then done=1, core_hold=0, error=0.
- Bad checksum:
  - Stimulus: same stream with final byte 0xAF.
  - Required: both writes occur, then error=1, done=0, core_hold=1, byte_ready=0.
- Illegal length:
  - Stimulus: bytes 00 00.
  - Required: error=1 right after LEN_LO, with no imem_we ever asserted.
  - Repeat with 01 01 (257) at MAX_WORDS=256: same response.
- Gaps:
  - Stimulus: the normal stream with byte_valid toggled randomly at 1:3 duty.
  - Required: identical writes, addresses and final done as the normal load; no byte dropped or duplicated.
- Restart mid-DATA:
  - Stimulus: pulse restart after 5 data bytes, then send the full normal stream.
  - Required: state returns to LEN_HI; the second load writes addresses 0 and 1 and ends with done=1.
- Reset mid-CHECK:
  - Stimulus: assert reset for 1 cycle while in CHECK.
  - Required: all outputs return to their reset values; byte_ready=0 during the reset cycle and 1 afterwards.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed, XOR-checksummed
// byte stream and writes big-endian 32-bit words to imem starting at address 0.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wd,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [15:0]             word_cnt_q, word_cnt_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [31:0]             asm_q, asm_d;
    logic [7:0]              csum_q, csum_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wd_q, wd_d;
    logic                    hold_q, hold_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    in_stream;
    logic                    accept;
    logic [15:0]             len_full;
    logic [31:0]             word_full;

    // States that consume stream bytes; reset and restart mask acceptance.
    always_comb begin
        in_stream = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CHECK);
        byte_ready = in_stream && !reset && !restart;
        accept     = byte_ready && byte_valid;
        len_full   = {len_q[15:8], byte_in};
        word_full  = {asm_q[23:0], byte_in};
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wd_d       = wd_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;

        if (restart) begin
            state_d    = S_LEN_HI;
            len_d      = 16'd0;
            word_cnt_d = 16'd0;
            byte_cnt_d = 2'd0;
            asm_d      = 32'd0;
            csum_d     = 8'd0;
            addr_d     = '0;
            hold_d     = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                S_LEN_HI: begin
                    if (accept) begin
                        len_d[15:8] = byte_in;
                        csum_d      = csum_q ^ byte_in;
                        state_d     = S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_d[7:0] = byte_in;
                        csum_d     = csum_q ^ byte_in;
                        if ((len_full == 16'd0) || (len_full > MAX_LEN)) begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                            hold_d  = 1'b1;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        asm_d  = word_full;
                        csum_d = csum_q ^ byte_in;
                        if (byte_cnt_q == 2'd3) begin
                            // Word complete: register the write for next cycle.
                            we_d       = 1'b1;
                            wd_d       = word_full;
                            addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
                            word_cnt_d = word_cnt_q + 16'd1;
                            byte_cnt_d = 2'd0;
                            if (word_cnt_q == (len_q - 16'd1)) begin
                                state_d = S_CHECK;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                end
                S_CHECK: begin
                    // The checksum byte is compared, never folded into the XOR.
                    if (accept) begin
                        if (byte_in == csum_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            hold_d  = 1'b0;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                            hold_d  = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_d = 1'b1;
                    hold_d = 1'b0;
                end
                S_ERROR: begin
                    err_d  = 1'b1;
                    hold_d = 1'b1;
                end
                default: begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                    hold_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_LEN_HI;
            len_q      <= 16'd0;
            word_cnt_q <= 16'd0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'd0;
            csum_q     <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wd_q       <= 32'd0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign imem_we   = we_q;
    assign imem_addr = addr_q;
    assign imem_wd   = wd_q;
    assign core_hold = hold_q;
    assign done      = done_q;
    assign error     = err_q;

endmodule
